// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the scanned 7-segment display interface
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_CODES  = 16;
  localparam logic [NUM_DIGITS-1:0] SEL_BLANK = 6'b111111;

  // Active-low segment codes for hex values 0..F; bit7 is dp, bits 6..0 are g..a.
  localparam logic [0:NUM_CODES-1][7:0] SEG_CODES = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } scan_state_e;

endpackage

// File: rtl/seg_to_num.sv
// rtl/seg_to_num.sv - active-low 7-segment pattern to hex value, inverse of the encoder
module seg_to_num
  import seg_pkg::*;
(
  input  logic [6:0] seg_pat,
  output logic       legal,
  output logic [3:0] value
);

  always_comb begin
    legal = 1'b0;
    value = 4'd0;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (seg_pat == SEG_CODES[i][6:0]) begin
        legal = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers per-digit values from a scanned active-low 7-segment bus
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int                    STABLE_CNT = 3,
  parameter logic [NUM_DIGITS-1:0] DIG_MASK   = 6'b111111
) (
  input  logic                  rst,
  input  logic                  div_clk,
  input  logic [NUM_DIGITS-1:0] sel_in,
  input  logic [7:0]            dig_in,
  output logic [3:0]            digit0,
  output logic [3:0]            digit1,
  output logic [3:0]            digit2,
  output logic [3:0]            digit3,
  output logic [3:0]            digit4,
  output logic [3:0]            digit5,
  output logic [NUM_DIGITS-1:0] digit_valid,
  output logic                  frame_done,
  output logic [NUM_DIGITS-1:0] dp_seen,
  output logic                  err
);

  logic [NUM_DIGITS-1:0] sel_s1_q, sel_s2_q, sel_prev_q;
  logic [7:0]            dig_s1_q, dig_s2_q, dig_prev_q;
  logic [3:0]            cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  scan_state_e           state_q, state_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d, seen_set;
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d, dp_q, dp_d;
  logic                  frame_q, frame_d, err_q, err_d;

  logic       change, blank, hit, one_hot, legal;
  logic [2:0] idx;
  logic [3:0] value;

  seg_to_num u_seg_to_num (
    .seg_pat (dig_s2_q[6:0]),
    .legal   (legal),
    .value   (value)
  );

  always_comb begin
    change  = {sel_s2_q, dig_s2_q} != {sel_prev_q, dig_prev_q};
    blank   = sel_s2_q == SEL_BLANK;
    one_hot = $countones(~sel_s2_q) == 1;
    idx     = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!sel_s2_q[k]) idx = 3'(k);
    end

    if (change)                          cnt_d = 4'd0;
    else if (cnt_q == 4'(STABLE_CNT))    cnt_d = cnt_q;
    else                                 cnt_d = cnt_q + 4'd1;

    // Capture lands on the edge where the counter reaches the threshold, once per arming.
    hit     = !blank && !change && armed_q && (cnt_d == 4'(STABLE_CNT));
    armed_d = change ? 1'b1 : (hit ? 1'b0 : armed_q);

    if (blank)                                       state_d = ST_IDLE;
    else if (hit || (state_q == ST_HOLD && !change)) state_d = ST_HOLD;
    else                                             state_d = ST_SETTLE;

    digit_d  = digit_q;
    valid_d  = valid_q;
    dp_d     = dp_q;
    seen_set = seen_q;
    err_d    = 1'b0;
    if (hit) begin
      if (one_hot && legal) begin
        digit_d[idx]  = value;
        valid_d[idx]  = 1'b1;
        dp_d[idx]     = ~dig_s2_q[7];
        seen_set[idx] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Frame completion clears seen in the same cycle, dropping any bit just set.
    frame_d = (seen_set & DIG_MASK) == DIG_MASK;
    seen_d  = frame_d ? '0 : seen_set;
  end

  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      sel_s1_q   <= SEL_BLANK;
      sel_s2_q   <= SEL_BLANK;
      sel_prev_q <= SEL_BLANK;
      dig_s1_q   <= 8'hFF;
      dig_s2_q   <= 8'hFF;
      dig_prev_q <= 8'hFF;
      cnt_q      <= 4'd0;
      armed_q    <= 1'b1;
      state_q    <= ST_IDLE;
      seen_q     <= '0;
      digit_q    <= '0;
      valid_q    <= '0;
      dp_q       <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sel_s1_q   <= sel_in;
      sel_s2_q   <= sel_s1_q;
      sel_prev_q <= sel_s2_q;
      dig_s1_q   <= dig_in;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      seen_q     <= seen_d;
      digit_q    <= digit_d;
      valid_q    <= valid_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign digit4      = digit_q[4];
  assign digit5      = digit_q[5];
  assign digit_valid = valid_q;
  assign dp_seen     = dp_q;
  assign frame_done  = frame_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed and randomized checks of the scan decoder
module tb_seg_scan_decoder;

  logic       rst, div_clk;
  logic [5:0] sel_in;
  logic [7:0] dig_in;
  logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
  logic [5:0] digit_valid, dp_seen;
  logic       frame_done, err;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int frame_cnt = 0;

  logic [7:0] codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_decoder dut (
    .rst         (rst),
    .div_clk     (div_clk),
    .sel_in      (sel_in),
    .dig_in      (dig_in),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit4      (digit4),
    .digit5      (digit5),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .dp_seen     (dp_seen),
    .err         (err)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  always @(negedge div_clk) begin
    if (err) err_cnt++;
    if (frame_done) frame_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge div_clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic [7:0] d, input int n);
    sel_in = s;
    dig_in = d;
    tick(n);
  endtask

  function automatic logic [3:0] dout(input int k);
    case (k)
      0: return digit0;
      1: return digit1;
      2: return digit2;
      3: return digit3;
      4: return digit4;
      default: return digit5;
    endcase
  endfunction

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] c;
      c = codes[i];
      if (c[6:0] == p) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  int         e0, f0;
  logic [3:0] m_dig [6];
  logic [5:0] m_val, m_dp, m_seen;
  int         m_err, m_frame;

  initial begin
    rst = 1'b0;
    sel_in = 6'h3F;
    dig_in = 8'hFF;
    tick(3);
    chk("reset_outputs", {digit5, digit4, digit3, digit2, digit1, digit0}, 0);
    chk("reset_flags", {digit_valid, dp_seen, frame_done, err}, 0);
    rst = 1'b1;
    tick(4);

    // Single capture latency: 2 sync + 3 stable + 1
    e0 = err_cnt;
    drive(6'h3E, 8'hC0, 5);
    chk("lat_before", digit_valid, 6'h00);
    tick(1);
    chk("lat_valid", digit_valid, 6'h01);
    chk("lat_digit0", digit0, 0);
    tick(4);
    chk("lat_no_err", err_cnt - e0, 0);
    drive(6'h3F, 8'hFF, 6);

    // Two full scans
    f0 = frame_cnt;
    for (int k = 0; k < 6; k++) begin
      drive(~(6'(1) << k), codes[k+1], 4);
      drive(6'h3F, 8'hFF, 2);
    end
    tick(6);
    for (int k = 0; k < 6; k++) chk($sformatf("scan1_digit%0d", k), dout(k), k + 1);
    chk("scan1_frames", frame_cnt - f0, 1);
    for (int k = 0; k < 6; k++) begin
      drive(~(6'(1) << k), codes[15-k], 4);
      drive(6'h3F, 8'hFF, 2);
    end
    tick(6);
    chk("scan2_digit5", digit5, 4'hA);
    chk("scan2_frames", frame_cnt - f0, 2);
    chk("scan2_dp", dp_seen, 6'h00);

    // Unknown pattern on digit 1
    e0 = err_cnt;
    f0 = frame_cnt;
    drive(6'h3D, 8'hFF, 5);
    drive(6'h3F, 8'hFF, 8);
    chk("bad_pat_err", err_cnt - e0, 1);
    chk("bad_pat_digit1", digit1, 4'hE);
    chk("bad_pat_valid", digit_valid, 6'h3F);
    chk("bad_pat_frame", frame_cnt - f0, 0);

    // Two selects low at once
    e0 = err_cnt;
    drive(6'h3C, 8'hC0, 6);
    drive(6'h3F, 8'hFF, 8);
    chk("multi_sel_err", err_cnt - e0, 1);
    chk("multi_sel_d0", digit0, 4'hF);
    chk("multi_sel_d1", digit1, 4'hE);

    // Short glitch inside a stable value on digit 2
    e0 = err_cnt;
    drive(6'h3B, 8'h90, 6);
    drive(6'h3B, 8'h80, 2);
    drive(6'h3B, 8'h90, 6);
    drive(6'h3F, 8'hFF, 8);
    chk("glitch_digit2", digit2, 4'h9);
    chk("glitch_no_err", err_cnt - e0, 0);

    // Reset mid-scan
    for (int k = 0; k < 3; k++) begin
      drive(~(6'(1) << k), codes[k+3], 4);
      drive(6'h3F, 8'hFF, 2);
    end
    drive(6'h37, codes[9], 2);
    #2 rst = 1'b0;
    #1;
    chk("midrst_digits", {digit5, digit4, digit3, digit2, digit1, digit0}, 0);
    chk("midrst_flags", {digit_valid, dp_seen, frame_done, err}, 0);
    sel_in = 6'h3F;
    dig_in = 8'hFF;
    tick(2);
    rst = 1'b1;
    tick(4);
    f0 = frame_cnt;
    for (int k = 0; k < 6; k++) begin
      drive(~(6'(1) << k), codes[k], 5);
      drive(6'h3F, 8'hFF, 3);
    end
    tick(6);
    chk("midrst_frames", frame_cnt - f0, 1);
    chk("midrst_valid", digit_valid, 6'h3F);

    // Randomized episodes against a rule-level model
    do_reset();
    tick(3);
    for (int k = 0; k < 6; k++) m_dig[k] = 4'd0;
    m_val = '0;
    m_dp = '0;
    m_seen = '0;
    m_err = 0;
    m_frame = 0;
    e0 = err_cnt;
    f0 = frame_cnt;
    for (int ep = 0; ep < 120; ep++) begin
      int r, len, nz, k, v;
      logic [5:0] s;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        s = ~(6'(1) << $urandom_range(0, 5));
      end else if (r < 8) begin
        int a, b;
        a = $urandom_range(0, 5);
        b = (a + $urandom_range(1, 5)) % 6;
        s = ~((6'(1) << a) | (6'(1) << b));
      end else begin
        s = 6'($urandom);
      end
      if ($urandom_range(0, 3) != 0) d = codes[$urandom_range(0, 15)];
      else d = 8'($urandom);
      d[7] = 1'($urandom);
      len = $urandom_range(1, 7);
      drive(s, d, len);
      drive(6'h3F, 8'hFF, $urandom_range(1, 3));

      nz = 0;
      k = 0;
      for (int i = 0; i < 6; i++) if (!s[i]) begin nz++; k = i; end
      if (nz != 0 && len >= 4) begin
        v = decode(d[6:0]);
        if (nz > 1 || v < 0) begin
          m_err++;
        end else begin
          m_dig[k] = 4'(v);
          m_val[k] = 1'b1;
          m_dp[k] = ~d[7];
          m_seen[k] = 1'b1;
          if (m_seen == 6'h3F) begin
            m_frame++;
            m_seen = '0;
          end
        end
      end
    end
    tick(8);
    for (int k = 0; k < 6; k++) chk($sformatf("rand_digit%0d", k), dout(k), m_dig[k]);
    chk("rand_valid", digit_valid, m_val);
    chk("rand_dp", dp_seen, m_dp);
    chk("rand_err", err_cnt - e0, m_err);
    chk("rand_frames", frame_cnt - f0, m_frame);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
